// File: rtl/piano_pkg.sv
// Shared note codes, ROM entry layout and sequencer state encoding.
package piano_pkg;

  localparam int unsigned CODE_W  = 4;
  localparam int unsigned DUR_W   = 3;
  localparam int unsigned ENTRY_W = CODE_W + DUR_W;
  localparam int unsigned NOTE_N  = 8;

  localparam logic [CODE_W-1:0] NOTE_C4   = 4'd0;
  localparam logic [CODE_W-1:0] NOTE_D4   = 4'd1;
  localparam logic [CODE_W-1:0] NOTE_E4   = 4'd2;
  localparam logic [CODE_W-1:0] NOTE_F4   = 4'd3;
  localparam logic [CODE_W-1:0] NOTE_G4   = 4'd4;
  localparam logic [CODE_W-1:0] NOTE_A4   = 4'd5;
  localparam logic [CODE_W-1:0] NOTE_B4   = 4'd6;
  localparam logic [CODE_W-1:0] NOTE_C5   = 4'd7;
  localparam logic [CODE_W-1:0] NOTE_REST = 4'd8;
  localparam logic [CODE_W-1:0] NOTE_END  = 4'd15;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BEAT = 3'd1,
    ST_FETCH     = 3'd2,
    ST_SOUND     = 3'd3,
    ST_GAP       = 3'd4,
    ST_FINISH    = 3'd5
  } seq_state_e;

  // A zero duration still lasts one eighth beat.
  function automatic logic [DUR_W-1:0] note_beats(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? DUR_W'(1) : dur;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational melody table; a flat image parameter can replace the built-in song.
module melody_rom
  import piano_pkg::*;
#(
  parameter int unsigned                   SONG_LEN  = 32,
  parameter int unsigned                   ADDR_W    = 5,
  parameter bit                            USE_IMAGE = 1'b0,
  parameter logic [SONG_LEN*ENTRY_W-1:0]   ROM_IMAGE = '0
) (
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [ENTRY_W-1:0] o_data_c
);

  if (USE_IMAGE) begin : g_image
    logic [ENTRY_W-1:0] w_image [SONG_LEN];

    for (genvar g = 0; g < SONG_LEN; g++) begin : g_entry
      assign w_image[g] = ROM_IMAGE[g*ENTRY_W +: ENTRY_W];
    end

    assign o_data_c = w_image[i_addr];
  end else begin : g_table
    // Built-in tune: twinkle-style phrase, rests, closing C5 and end marker.
    always_comb begin
      o_data_c = {NOTE_END, 3'd0};
      case (32'(i_addr))
        0:  o_data_c = {NOTE_C4,   3'd1};
        1:  o_data_c = {NOTE_C4,   3'd1};
        2:  o_data_c = {NOTE_G4,   3'd1};
        3:  o_data_c = {NOTE_G4,   3'd1};
        4:  o_data_c = {NOTE_A4,   3'd1};
        5:  o_data_c = {NOTE_A4,   3'd1};
        6:  o_data_c = {NOTE_G4,   3'd2};
        7:  o_data_c = {NOTE_F4,   3'd1};
        8:  o_data_c = {NOTE_F4,   3'd1};
        9:  o_data_c = {NOTE_E4,   3'd1};
        10: o_data_c = {NOTE_E4,   3'd1};
        11: o_data_c = {NOTE_D4,   3'd1};
        12: o_data_c = {NOTE_D4,   3'd1};
        13: o_data_c = {NOTE_C4,   3'd2};
        14: o_data_c = {NOTE_REST, 3'd1};
        15: o_data_c = {NOTE_G4,   3'd1};
        16: o_data_c = {NOTE_G4,   3'd1};
        17: o_data_c = {NOTE_F4,   3'd1};
        18: o_data_c = {NOTE_F4,   3'd1};
        19: o_data_c = {NOTE_E4,   3'd1};
        20: o_data_c = {NOTE_E4,   3'd1};
        21: o_data_c = {NOTE_D4,   3'd2};
        22: o_data_c = {NOTE_G4,   3'd1};
        23: o_data_c = {NOTE_G4,   3'd1};
        24: o_data_c = {NOTE_F4,   3'd1};
        25: o_data_c = {NOTE_F4,   3'd1};
        26: o_data_c = {NOTE_E4,   3'd1};
        27: o_data_c = {NOTE_E4,   3'd1};
        28: o_data_c = {NOTE_D4,   3'd2};
        29: o_data_c = {NOTE_C5,   3'd2};
        30: o_data_c = {NOTE_REST, 3'd2};
        31: o_data_c = {NOTE_END,  3'd0};
        default: o_data_c = {NOTE_END, 3'd0};
      endcase
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Speaker source selector: manual keys in IDLE, beat-aligned melody autoplay otherwise.
module note_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned                 SONG_LEN   = 32,
  parameter int unsigned                 ADDR_W     = 5,
  parameter int unsigned                 GAP_CYCLES = 16,
  parameter bit                          USE_IMAGE  = 1'b0,
  parameter logic [SONG_LEN*ENTRY_W-1:0] ROM_IMAGE  = '0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NOTE_N-1:0] i_note_clks,
  input  logic              i_eighth_beat,
  input  logic [NOTE_N-1:0] i_keys,
  input  logic              i_play,
  input  logic              i_stop,
  input  logic              i_loop,
  output logic              o_speaker,
  output logic [CODE_W-1:0] o_note_idx,
  output logic              o_busy,
  output logic              o_song_done
);

  localparam int unsigned GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  seq_state_e         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [CODE_W-1:0]  r_cur_code;
  logic [DUR_W-1:0]   r_remaining;
  logic [GAP_W-1:0]   r_gap;
  logic               r_beat_q;
  logic               r_play_q;
  logic               r_busy;
  logic               r_done;
  logic               r_speaker;
  logic [CODE_W-1:0]  r_note_idx;

  logic [ENTRY_W-1:0] w_rom_data;
  rom_entry_t         w_entry;
  logic               w_beat_tick;
  logic               w_play_rise;
  logic [CODE_W-1:0]  w_key_code;
  logic [CODE_W-1:0]  w_sound_code;

  melody_rom #(
    .SONG_LEN  (SONG_LEN),
    .ADDR_W    (ADDR_W),
    .USE_IMAGE (USE_IMAGE),
    .ROM_IMAGE (ROM_IMAGE)
  ) u_rom (
    .i_addr   (r_addr),
    .o_data_c (w_rom_data)
  );

  assign w_entry     = rom_entry_t'(w_rom_data);
  assign w_beat_tick = i_eighth_beat & ~r_beat_q;
  assign w_play_rise = i_play & ~r_play_q;

  // Previous-cycle copies of the beat and PLAY levels for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_beat_q <= 1'b0;
      r_play_q <= 1'b0;
    end else begin
      r_beat_q <= i_eighth_beat;
      r_play_q <= i_play;
    end
  end

  // Manual key priority: lowest set bit wins, no key means rest.
  always_comb begin
    w_key_code = NOTE_REST;
    for (int i = NOTE_N - 1; i >= 0; i--) begin
      if (i_keys[i]) w_key_code = CODE_W'(i);
    end
  end

  // Code that should sound now; only SOUND with a real note or IDLE keys are audible.
  always_comb begin
    w_sound_code = NOTE_REST;
    if (r_state == ST_IDLE) begin
      w_sound_code = w_key_code;
    end else if (r_state == ST_SOUND && !r_cur_code[CODE_W-1]) begin
      w_sound_code = r_cur_code;
    end
  end

  // Autoplay sequencer; STOP overrides every busy state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_cur_code  <= NOTE_REST;
      r_remaining <= '0;
      r_gap       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE && i_stop) begin
        r_state <= ST_IDLE;
        r_addr  <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_play_rise) begin
              r_addr  <= '0;
              r_state <= ST_WAIT_BEAT;
              r_busy  <= 1'b1;
            end
          end
          ST_WAIT_BEAT: begin
            if (w_beat_tick) r_state <= ST_FETCH;
          end
          ST_FETCH: begin
            if (w_entry.code == NOTE_END) begin
              if (i_loop) begin
                r_addr <= '0;
              end else begin
                r_state <= ST_FINISH;
                r_done  <= 1'b1;
              end
            end else begin
              r_cur_code  <= w_entry.code;
              r_remaining <= note_beats(w_entry.dur);
              r_state     <= ST_SOUND;
            end
          end
          ST_SOUND: begin
            if (w_beat_tick) begin
              if (r_remaining <= DUR_W'(1)) begin
                r_gap   <= GAP_W'(GAP_CYCLES);
                r_state <= ST_GAP;
              end else begin
                r_remaining <= r_remaining - 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (r_gap <= GAP_W'(1)) begin
              if (r_addr == LAST_ADDR) begin
                if (i_loop) begin
                  r_addr  <= '0;
                  r_state <= ST_FETCH;
                end else begin
                  r_state <= ST_FINISH;
                  r_done  <= 1'b1;
                end
              end else begin
                r_addr  <= r_addr + 1'b1;
                r_state <= ST_FETCH;
              end
            end else begin
              r_gap <= r_gap - 1'b1;
            end
          end
          ST_FINISH: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered speaker drive and note index, one cycle behind the selection.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_speaker  <= 1'b0;
      r_note_idx <= NOTE_REST;
    end else begin
      r_speaker  <= ~w_sound_code[CODE_W-1] & i_note_clks[w_sound_code[2:0]];
      r_note_idx <= w_sound_code;
    end
  end

  assign o_speaker   = r_speaker;
  assign o_note_idx  = r_note_idx;
  assign o_busy      = r_busy;
  assign o_song_done = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized bench for note_sequencer: two instances (short test song, 32-entry song without end marker).
module tb_note_sequencer;
  import piano_pkg::*;

  localparam int unsigned SONG_LEN  = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned BEAT_HALF = 20;
  localparam int          GAP_A     = 4;
  localparam int          GAP_B     = 6;

  // A sounds 2 beats, rest 1 beat, C5 1 beat, then end marker.
  function automatic logic [SONG_LEN*ENTRY_W-1:0] make_rom_a();
    logic [SONG_LEN*ENTRY_W-1:0] r;
    r = '0;
    r[0*ENTRY_W +: ENTRY_W] = {4'd5, 3'd2};
    r[1*ENTRY_W +: ENTRY_W] = {4'd8, 3'd1};
    r[2*ENTRY_W +: ENTRY_W] = {4'd7, 3'd1};
    r[3*ENTRY_W +: ENTRY_W] = {4'd15, 3'd0};
    return r;
  endfunction

  // No end marker; codes 0..9 (8 and 9 silent), durations 0..3 (0 counts as 1).
  function automatic logic [SONG_LEN*ENTRY_W-1:0] make_rom_b();
    logic [SONG_LEN*ENTRY_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(SONG_LEN); i++) begin
      r[i*ENTRY_W +: ENTRY_W] = {4'((i * 3) % 10), 3'(i % 4)};
    end
    return r;
  endfunction

  localparam logic [SONG_LEN*ENTRY_W-1:0] ROM_A = make_rom_a();
  localparam logic [SONG_LEN*ENTRY_W-1:0] ROM_B = make_rom_b();

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] note_clks = '0;
  logic       beat = 1'b0;
  logic [7:0] keys = '0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;

  logic       spk  [2];
  logic [3:0] idx  [2];
  logic       busy [2];
  logic       done [2];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int done_cnt_a = 0;

  always #5 clk = ~clk;

  note_sequencer #(
    .SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP_A),
    .USE_IMAGE(1'b1), .ROM_IMAGE(ROM_A)
  ) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_note_clks(note_clks), .i_eighth_beat(beat),
    .i_keys(keys), .i_play(play), .i_stop(stop), .i_loop(loop),
    .o_speaker(spk[0]), .o_note_idx(idx[0]), .o_busy(busy[0]), .o_song_done(done[0])
  );

  note_sequencer #(
    .SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP_B),
    .USE_IMAGE(1'b1), .ROM_IMAGE(ROM_B)
  ) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_note_clks(note_clks), .i_eighth_beat(beat),
    .i_keys(keys), .i_play(play), .i_stop(stop), .i_loop(loop),
    .o_speaker(spk[1]), .o_note_idx(idx[1]), .o_busy(busy[1]), .o_song_done(done[1])
  );

  // ---------------- behavioural reference ----------------
  // Player activity: silent, waiting for the first beat, reading the next cue,
  // holding a note for some beats, breathing between notes, announcing the end.
  localparam int ACT_SILENT = 0, ACT_ARMED = 1, ACT_CUE = 2, ACT_HOLD = 3, ACT_BREATH = 4, ACT_END = 5;

  int   song_code [2][SONG_LEN];
  int   song_dur  [2][SONG_LEN];
  int   gap_len   [2];
  int   act       [2];
  int   pos       [2];
  int   playing   [2];
  int   beats_left[2];
  int   breath    [2];
  logic prev_beat, prev_play;

  int   e_idx  [2];
  logic e_spk  [2];
  logic e_busy [2];
  logic e_done [2];

  function automatic int first_key(input logic [7:0] k);
    for (int i = 0; i < 8; i++) if (k[i]) return i;
    return 8;
  endfunction

  task automatic load_songs();
    logic [SONG_LEN*ENTRY_W-1:0] img [2];
    img[0] = ROM_A;
    img[1] = ROM_B;
    gap_len[0] = GAP_A;
    gap_len[1] = GAP_B;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(SONG_LEN); i++) begin
        song_code[d][i] = int'(img[d][i*ENTRY_W+3 +: 4]);
        song_dur[d][i]  = int'(img[d][i*ENTRY_W +: 3]);
      end
    end
  endtask

  task automatic model_reset();
    prev_beat = 1'b0;
    prev_play = 1'b0;
    for (int d = 0; d < 2; d++) begin
      act[d] = ACT_SILENT; pos[d] = 0; playing[d] = 8; beats_left[d] = 0; breath[d] = 0;
      e_idx[d] = 8; e_spk[d] = 1'b0; e_busy[d] = 1'b0; e_done[d] = 1'b0;
    end
  endtask

  // Advance to the next song position; past the last slot the song ends or wraps.
  task automatic next_slot(input int d);
    if (pos[d] == int'(SONG_LEN) - 1) begin
      if (loop) begin pos[d] = 0; act[d] = ACT_CUE; end
      else begin act[d] = ACT_END; e_done[d] = 1'b1; end
    end else begin
      pos[d]++;
      act[d] = ACT_CUE;
    end
  endtask

  task automatic model_step();
    bit tick, rise;
    int heard;
    tick = beat && !prev_beat;
    rise = play && !prev_play;
    for (int d = 0; d < 2; d++) begin
      heard = 8;
      if (act[d] == ACT_SILENT) heard = first_key(keys);
      else if (act[d] == ACT_HOLD && playing[d] < 8) heard = playing[d];
      e_idx[d]  = heard;
      e_spk[d]  = (heard < 8) ? note_clks[heard] : 1'b0;
      e_done[d] = 1'b0;
      if (act[d] != ACT_SILENT && stop) begin
        act[d] = ACT_SILENT; pos[d] = 0;
      end else begin
        case (act[d])
          ACT_SILENT: if (rise) begin pos[d] = 0; act[d] = ACT_ARMED; end
          ACT_ARMED:  if (tick) act[d] = ACT_CUE;
          ACT_CUE: begin
            if (song_code[d][pos[d]] == 15) begin
              if (loop) pos[d] = 0;
              else begin act[d] = ACT_END; e_done[d] = 1'b1; end
            end else begin
              playing[d]    = song_code[d][pos[d]];
              beats_left[d] = (song_dur[d][pos[d]] == 0) ? 1 : song_dur[d][pos[d]];
              act[d] = ACT_HOLD;
            end
          end
          ACT_HOLD: if (tick) begin
            beats_left[d]--;
            if (beats_left[d] == 0) begin breath[d] = gap_len[d]; act[d] = ACT_BREATH; end
          end
          ACT_BREATH: begin
            breath[d]--;
            if (breath[d] == 0) next_slot(d);
          end
          default: act[d] = ACT_SILENT;
        endcase
      end
      e_busy[d] = (act[d] != ACT_SILENT);
    end
    prev_beat = beat;
    prev_play = play;
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    string s;
    for (int d = 0; d < 2; d++) begin
      s = (d == 0) ? "a" : "b";
      check_val({"note_idx_", s}, int'(idx[d]), e_idx[d]);
      check_val({"speaker_", s}, int'(spk[d]), int'(e_spk[d]));
      check_val({"busy_", s}, int'(busy[d]), int'(e_busy[d]));
      check_val({"song_done_", s}, int'(done[d]), int'(e_done[d]));
    end
    if (done[0]) done_cnt_a++;
  endtask

  task automatic drive_gen();
    for (int i = 0; i < 8; i++) note_clks[i] = ((cyc / (i + 2)) % 2) != 0;
    beat = (cyc % (2 * BEAT_HALF)) < BEAT_HALF;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
    cyc++;
    drive_gen();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_play();
    play = 1'b1; cycle();
    play = 1'b0; cycle();
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while ((act[0] != ACT_SILENT || act[1] != ACT_SILENT) && n < limit) begin
      cycle();
      n++;
    end
    check_val(tag, int'(act[0] == ACT_SILENT && act[1] == ACT_SILENT), 1);
  endtask

  task automatic wait_note_a(input string tag, input int code, input int limit);
    int n;
    n = 0;
    while (!(act[0] == ACT_HOLD && playing[0] == code) && n < limit) begin
      cycle();
      n++;
    end
    check_val(tag, int'(act[0] == ACT_HOLD && playing[0] == code), 1);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val({tag, "_speaker"}, int'(spk[d]), 0);
      check_val({tag, "_note_idx"}, int'(idx[d]), 8);
      check_val({tag, "_busy"}, int'(busy[d]), 0);
      check_val({tag, "_done"}, int'(done[d]), 0);
    end
    model_reset();
    play = 1'b0; stop = 1'b0;
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    load_songs();
    model_reset();
    drive_gen();
    #2;
    apply_reset("por");

    // manual keys: lowest index wins, none -> silence
    keys = 8'b0010_0100;
    run(6);
    keys = 8'h00;
    run(4);
    for (int i = 0; i < 40; i++) begin
      keys = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cycle();
    end

    // single play, keys hammered while busy
    keys = 8'hFF;
    loop = 1'b0;
    done_cnt_a = 0;
    pulse_play();
    wait_idle("song_once_timeout", 8000);
    check_val("done_pulses_once", done_cnt_a, 1);

    // looping: no done pulse while LOOP held, then finish on next end marker
    done_cnt_a = 0;
    loop = 1'b1;
    pulse_play();
    run(3000);
    check_val("done_pulses_loop", done_cnt_a, 0);
    loop = 1'b0;
    wait_idle("loop_exit_timeout", 8000);
    check_val("done_pulses_loop_exit", done_cnt_a, 1);

    // STOP together with a PLAY edge while a note sounds
    keys = 8'h00;
    pulse_play();
    wait_note_a("wait_sound_a", 5, 400);
    play = 1'b1; stop = 1'b1;
    cycle();
    play = 1'b0; stop = 1'b0;
    cycle();
    check_val("stop_busy_a", int'(busy[0]), 0);
    pulse_play();
    run(300);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) keys = 8'($urandom);
      if ($urandom_range(0, 59) == 0) play = ~play;
      stop = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 399) == 0) loop = ~loop;
      cycle();
    end
    stop = 1'b0; play = 1'b0; loop = 1'b0;
    cycle();
    stop = 1'b1; cycle(); stop = 1'b0; cycle();

    // reset while a note is sounding, then restart from the top
    pulse_play();
    wait_note_a("wait_sound_rst", 5, 400);
    apply_reset("mid_sound");
    pulse_play();
    run(400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
